// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// Scans BCD digits from a per-frame snapshot, with anode guard time and leading-zero blanking.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 4
) (
    input  logic        clk100Mhz,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] presc, presc_nxt;
    logic [PW-1:0] guard, guard_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   snap_d, snap_d_nxt;
    logic [3:0]    snap_dp, snap_dp_nxt;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic          tick_c;
    logic [3:0]    lz_c;
    logic [3:0]    digit_c;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Prescaler, digit index, guard countdown and frame snapshot
    always_comb begin
        tick_c      = en && (presc == PW'(REFRESH_DIV - 1));
        presc_nxt   = presc;
        idx_nxt     = idx;
        guard_nxt   = guard;
        snap_d_nxt  = snap_d;
        snap_dp_nxt = snap_dp;
        if (tick_c) begin
            presc_nxt = '0;
            idx_nxt   = idx + 2'd1;
            guard_nxt = PW'(GUARD);
            if (idx == 2'd3) begin
                snap_d_nxt  = digits;
                snap_dp_nxt = dp_en;
            end
        end else begin
            if (en) begin
                presc_nxt = presc + PW'(1);
            end
            if (guard != '0) begin
                guard_nxt = guard - PW'(1);
            end
        end
    end

    // A digit is a leading zero only if it and every higher digit are zero
    always_comb begin
        lz_c[3] = (snap_d_nxt[15:12] == 4'd0);
        lz_c[2] = lz_c[3] && (snap_d_nxt[11:8] == 4'd0);
        lz_c[1] = lz_c[2] && (snap_d_nxt[7:4] == 4'd0);
        lz_c[0] = 1'b0;
        digit_c = snap_d_nxt[{idx_nxt, 2'b00} +: 4];
    end

    // Output decode from the post-edge state so anodes move with the index
    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = 7'b1111111;
        dp_nxt  = 1'b1;
        if (en && (guard_nxt == '0)) begin
            an_nxt = ~(4'b0001 << idx_nxt);
            dp_nxt = ~snap_dp_nxt[idx_nxt];
            if (!(blank_lz && lz_c[idx_nxt])) begin
                seg_nxt = bcd_to_seg(digit_c);
            end
        end
    end

    always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            idx     <= 2'd0;
            guard   <= '0;
            snap_d  <= 16'h0000;
            snap_dp <= 4'b0000;
            an      <= 4'b1111;
            seg     <= 7'b1111111;
            dp      <= 1'b1;
        end else begin
            presc   <= presc_nxt;
            idx     <= idx_nxt;
            guard   <= guard_nxt;
            snap_d  <= snap_d_nxt;
            snap_dp <= snap_dp_nxt;
            an      <= an_nxt;
            seg     <= seg_nxt;
            dp      <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: cycle-level model built from enabled-edge counts,
// plus directed scan scenarios with literal segment expectations.
module tb_seven_seg_scanner;

    localparam int unsigned DIV = 4;
    localparam int unsigned GRD = 1;

    logic        clk100Mhz;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    seven_seg_scanner #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
        .clk100Mhz (clk100Mhz),
        .rst       (rst),
        .en        (en),
        .digits    (digits),
        .dp_en     (dp_en),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    initial clk100Mhz = 1'b0;
    always #5 clk100Mhz = ~clk100Mhz;

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %b required %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
              7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        return t[v];
    endfunction

    // Model: everything follows from the count of edges and of enabled edges since reset
    int unsigned edges, en_edges, ticks, last_tick;
    logic [15:0] m_snap;
    logic [3:0]  m_snapdp;
    logic        m_en;

    always @(posedge clk100Mhz or posedge rst) begin
        if (rst) begin
            edges = 0; en_edges = 0; ticks = 0; last_tick = 0;
            m_snap = 16'h0000; m_snapdp = 4'b0000; m_en = 1'b0;
        end else begin
            edges++;
            m_en = en;
            if (en) begin
                en_edges++;
                if (en_edges % DIV == 0) begin
                    ticks++;
                    last_tick = edges;
                    if (ticks % 4 == 0) begin
                        m_snap   = digits;
                        m_snapdp = dp_en;
                    end
                end
            end
        end
    end

    always @(posedge clk100Mhz) begin
        int   i;
        logic active, blank;
        logic [3:0] e_an;
        #1;
        if (rst) begin
            check("m_rst_an", {3'b0, an}, 7'b0001111);
            check("m_rst_seg", seg, 7'b1111111);
            check("m_rst_dp", {6'b0, dp}, 7'd1);
        end else begin
            i      = int'(ticks % 4);
            active = m_en && (ticks == 0 || (edges - last_tick) >= GRD);
            e_an   = active ? ~(4'b0001 << i) : 4'b1111;
            check("m_an", {3'b0, an}, {3'b0, e_an});
            check("m_dp", {6'b0, dp}, {6'b0, active ? ~m_snapdp[i] : 1'b1});
            if (active) begin
                blank = 1'b0;
                if (blank_lz && i != 0) begin
                    blank = 1'b1;
                    for (int j = i; j < 4; j++)
                        if (m_snap[4*j +: 4] != 4'd0) blank = 1'b0;
                end
                check("m_seg", seg, blank ? 7'b1111111 : dec(m_snap[4*i +: 4]));
            end
        end
    end

    task automatic step();
        @(posedge clk100Mhz);
        #2;
    endtask

    task automatic wait_an(input logic [3:0] a);
        int n = 0;
        while (an !== a && n < 40) begin
            step();
            n++;
        end
        check("wait_an", {3'b0, an}, {3'b0, a});
    endtask

    // Wait for a digit slot, check its segments/dp, then check the guard gap that ends it
    task automatic show(input string nm, input logic [3:0] a, input logic [6:0] s, input logic d);
        int n = 0;
        wait_an(a);
        check({nm, "_seg"}, seg, s);
        check({nm, "_dp"}, {6'b0, dp}, {6'b0, d});
        while (an === a && n < 10) begin
            step();
            n++;
        end
        check({nm, "_gap"}, {3'b0, an}, 7'b0001111);
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; digits = 16'h0000; dp_en = 4'b0000; blank_lz = 1'b0;
        repeat (3) step();
        rst = 1'b0; en = 1'b1; digits = 16'h1234;
        step();
        check("first_an", {3'b0, an}, 7'b0001110);
        check("first_seg", seg, 7'b1000000);

        // Scan order
        wait_an(4'b0111);
        show("s1234_d0", 4'b1110, 7'b0011001, 1'b1);
        show("s1234_d1", 4'b1101, 7'b0110000, 1'b1);
        show("s1234_d2", 4'b1011, 7'b0100100, 1'b1);
        show("s1234_d3", 4'b0111, 7'b1111001, 1'b1);

        // Leading zeros
        digits = 16'h0050; blank_lz = 1'b1;
        wait_an(4'b0111);
        show("lz_d0", 4'b1110, 7'b1000000, 1'b1);
        show("lz_d1", 4'b1101, 7'b0010010, 1'b1);
        show("lz_d2", 4'b1011, 7'b1111111, 1'b1);
        show("lz_d3", 4'b0111, 7'b1111111, 1'b1);
        blank_lz = 1'b0;
        show("nolz_d0", 4'b1110, 7'b1000000, 1'b1);
        show("nolz_d1", 4'b1101, 7'b0010010, 1'b1);
        show("nolz_d2", 4'b1011, 7'b1000000, 1'b1);
        show("nolz_d3", 4'b0111, 7'b1000000, 1'b1);

        // Dash stops blanking; decimal point on digit 0
        digits = 16'h0A00; dp_en = 4'b0001; blank_lz = 1'b1;
        wait_an(4'b0111);
        show("dash_d0", 4'b1110, 7'b1000000, 1'b0);
        show("dash_d1", 4'b1101, 7'b1000000, 1'b1);
        show("dash_d2", 4'b1011, 7'b0111111, 1'b1);
        show("dash_d3", 4'b0111, 7'b1111111, 1'b1);

        // Frame coherency
        digits = 16'h1111; dp_en = 4'b0000; blank_lz = 1'b0;
        wait_an(4'b0111);
        show("coh_d0", 4'b1110, 7'b1111001, 1'b1);
        wait_an(4'b1101);
        digits = 16'h2222;
        show("coh_d1", 4'b1101, 7'b1111001, 1'b1);
        show("coh_d2", 4'b1011, 7'b1111001, 1'b1);
        show("coh_d3", 4'b0111, 7'b1111001, 1'b1);
        show("new_d0", 4'b1110, 7'b0100100, 1'b1);
        show("new_d1", 4'b1101, 7'b0100100, 1'b1);
        show("new_d2", 4'b1011, 7'b0100100, 1'b1);
        show("new_d3", 4'b0111, 7'b0100100, 1'b1);

        // Enable freeze mid-slot: two edges were left in the digit-1 slot
        wait_an(4'b1101);
        step();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("frz_an", {3'b0, an}, 7'b0001111);
        end
        en = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (an !== 4'b1101) break;
            n++;
        end
        check("frz_left", 7'(n), 7'd1);
        step();
        check("frz_next", {3'b0, an}, 7'b0001011);

        // Async reset between edges at index 2
        wait_an(4'b1011);
        #2;
        rst = 1'b1;
        #1;
        check("arst_an", {3'b0, an}, 7'b0001111);
        check("arst_seg", seg, 7'b1111111);
        check("arst_dp", {6'b0, dp}, 7'd1);
        step();
        step();
        rst = 1'b0;
        step();
        check("rel_an", {3'b0, an}, 7'b0001110);
        check("rel_seg", seg, 7'b1000000);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
